// File: rtl/posit_decode_pipe_if.sv
// Stream interface for posit_decode_pipe: packed posit in, unpacked fields out.
// Handshake rule for both sides: a word transfers on a rising clock edge where
// valid and ready are both high. Valid may not drop, and data may not change,
// until that transfer has happened.
interface posit_decode_pipe_if #(
    parameter int WIDTH = 8,
    parameter int ES    = 1
);
    localparam int EXP_BITS  = $clog2(2*WIDTH-3) + ES;
    localparam int FRAC_BITS = WIDTH - 3 - ES;

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_bits;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_sign;
    logic                 out_is_zero;
    logic                 out_is_inf;
    logic [EXP_BITS-1:0]  out_exponent;
    logic [FRAC_BITS-1:0] out_fraction;

    // Environment side: produces posits, consumes unpacked results.
    modport master (
        output in_valid, in_bits, out_ready,
        input  in_ready, out_valid, out_sign, out_is_zero, out_is_inf,
               out_exponent, out_fraction
    );

    // Decoder side.
    modport slave (
        input  in_valid, in_bits, out_ready,
        output in_ready, out_valid, out_sign, out_is_zero, out_is_inf,
               out_exponent, out_fraction
    );
endinterface

// File: rtl/posit_decode_pipe.sv
// Two-stage streaming posit decoder (packed posit -> sign/zero/inf/biased
// exponent/fraction). Stage 1 counts the regime run, stage 2 shifts the regime
// out and slices es and fraction. Optional feature macro: POSIT_DECODE_STATS_EN
// adds saturating zero/infinity output counters and their ports.
module posit_decode_pipe #(
    parameter int WIDTH = 8,
    parameter int ES    = 1
) (
    input  logic               clock,
    input  logic               resetn,
    posit_decode_pipe_if.slave bus
`ifdef POSIT_DECODE_STATS_EN
    ,
    output logic [31:0]        stat_zero_count,
    output logic [31:0]        stat_inf_count
`endif
);
    localparam int EXP_BITS  = $clog2(2*WIDTH-3) + ES;
    localparam int FRAC_BITS = WIDTH - 3 - ES;
    localparam int RBITS     = $clog2(2*WIDTH-3);
    localparam int KBITS     = $clog2(WIDTH);
    localparam int BODY      = WIDTH - 1;

    // ---------------- stage 1: regime run detection ----------------
    logic [BODY-1:0]  body;
    logic [KBITS-1:0] run_len;
    logic             run_open;
    logic             is_zero_d, is_inf_d, special;
    logic             sign_d;
    logic [RBITS-1:0] ureg_d;
    logic [KBITS-1:0] shift_d;
    logic [BODY-1:0]  body_d;

    assign body      = bus.in_bits[WIDTH-2:0];
    assign is_zero_d = (bus.in_bits == '0);
    assign is_inf_d  = (bus.in_bits == {1'b1, {(WIDTH-1){1'b0}}});
    assign special   = is_zero_d || is_inf_d;

    // Length of the leading run of bits equal to the body MSB (at most BODY).
    always_comb begin
        run_len  = '0;
        run_open = 1'b1;
        for (int i = BODY-1; i >= 0; i--) begin
            if (run_open && (body[i] == body[BODY-1])) begin
                run_len = run_len + 1'b1;
            end else begin
                run_open = 1'b0;
            end
        end
    end

    // Unsigned regime, shift past run+terminator, and zeroed fields for specials.
    always_comb begin
        sign_d  = 1'b0;
        ureg_d  = '0;
        shift_d = '0;
        body_d  = '0;
        if (!special) begin
            sign_d = bus.in_bits[WIDTH-1];
            body_d = body;
            if (body[BODY-1]) begin
                ureg_d = RBITS'(int'(run_len) + WIDTH - 3);
            end else begin
                ureg_d = RBITS'(WIDTH - 2 - int'(run_len));
            end
            if (int'(run_len) + 1 > BODY) begin
                shift_d = KBITS'(BODY);
            end else begin
                shift_d = KBITS'(int'(run_len) + 1);
            end
        end
    end

    // ---------------- pipeline control ----------------
    logic s1_valid_q, s2_valid_q;
    logic s1_load, s2_load;

    assign s2_load      = !s2_valid_q || bus.out_ready;
    assign s1_load      = !s1_valid_q || s2_load;
    assign bus.in_ready = s1_load;

    logic             s1_sign_q, s1_zero_q, s1_inf_q;
    logic [RBITS-1:0] s1_ureg_q;
    logic [KBITS-1:0] s1_shift_q;
    logic [BODY-1:0]  s1_body_q;

    // Stage 1 register: accept a new word whenever the stage can hand off.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_inf_q   <= 1'b0;
            s1_ureg_q  <= '0;
            s1_shift_q <= '0;
            s1_body_q  <= '0;
        end else if (s1_load) begin
            s1_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sign_q  <= sign_d;
                s1_zero_q  <= is_zero_d;
                s1_inf_q   <= is_inf_d;
                s1_ureg_q  <= ureg_d;
                s1_shift_q <= shift_d;
                s1_body_q  <= body_d;
            end
        end
    end

    // ---------------- stage 2: field extraction ----------------
    logic [BODY-1:0]      rem;
    logic [EXP_BITS-1:0]  es_val;
    logic [EXP_BITS-1:0]  exp_d;
    logic [FRAC_BITS-1:0] frac_d;

    // Remainder after the regime: top ES bits are es, next FRAC_BITS are fraction.
    always_comb begin
        rem    = s1_body_q << s1_shift_q;
        es_val = EXP_BITS'(rem >> (BODY - ES));
        exp_d  = (EXP_BITS'(s1_ureg_q) << ES) | es_val;
        frac_d = FRAC_BITS'(rem >> (BODY - ES - FRAC_BITS));
    end

    logic                 s2_sign_q, s2_zero_q, s2_inf_q;
    logic [EXP_BITS-1:0]  s2_exp_q;
    logic [FRAC_BITS-1:0] s2_frac_q;

    // Stage 2 register: outputs hold while the consumer stalls.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_zero_q  <= 1'b0;
            s2_inf_q   <= 1'b0;
            s2_exp_q   <= '0;
            s2_frac_q  <= '0;
        end else if (s2_load) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_sign_q <= s1_sign_q;
                s2_zero_q <= s1_zero_q;
                s2_inf_q  <= s1_inf_q;
                s2_exp_q  <= exp_d;
                s2_frac_q <= frac_d;
            end
        end
    end

    assign bus.out_valid    = s2_valid_q;
    assign bus.out_sign     = s2_sign_q;
    assign bus.out_is_zero  = s2_zero_q;
    assign bus.out_is_inf   = s2_inf_q;
    assign bus.out_exponent = s2_exp_q;
    assign bus.out_fraction = s2_frac_q;

`ifdef POSIT_DECODE_STATS_EN
    logic        out_fire;
    logic [31:0] zero_cnt_q, inf_cnt_q;

    assign out_fire = s2_valid_q && bus.out_ready;

    // Saturating counts of delivered zero / infinity results.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            zero_cnt_q <= '0;
            inf_cnt_q  <= '0;
        end else if (out_fire) begin
            if (s2_zero_q && (zero_cnt_q != 32'hFFFF_FFFF)) begin
                zero_cnt_q <= zero_cnt_q + 32'd1;
            end
            if (s2_inf_q && (inf_cnt_q != 32'hFFFF_FFFF)) begin
                inf_cnt_q <= inf_cnt_q + 32'd1;
            end
        end
    end

    assign stat_zero_count = zero_cnt_q;
    assign stat_inf_count  = inf_cnt_q;
`endif

endmodule

// File: tb/tb_posit_decode_pipe.sv
// Directed bench for posit_decode_pipe (WIDTH=8, ES=1). Expected words are
// packed as {sign, is_zero, is_inf, exponent[4:0], fraction[3:0]}.
module tb_posit_decode_pipe;
    localparam int W  = 8;
    localparam int ES = 1;

    // ---------------- clock / reset ----------------
    logic clock  = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    posit_decode_pipe_if #(.WIDTH(W), .ES(ES)) bus ();

`ifdef POSIT_DECODE_STATS_EN
    logic [31:0] stat_zero_count;
    logic [31:0] stat_inf_count;
`endif

    posit_decode_pipe #(.WIDTH(W), .ES(ES)) dut (
        .clock           (clock),
        .resetn          (resetn),
        .bus             (bus)
`ifdef POSIT_DECODE_STATS_EN
        ,
        .stat_zero_count (stat_zero_count),
        .stat_inf_count  (stat_inf_count)
`endif
    );

    // ---------------- scoreboard state ----------------
    int          n_cmp = 0;
    int          n_err = 0;
    logic [11:0] exp_q[$];
    int          exp_zero_hs = 0;
    int          exp_inf_hs  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [11:0] out_word();
        return {bus.out_sign, bus.out_is_zero, bus.out_is_inf, bus.out_exponent, bus.out_fraction};
    endfunction

    // Monitor: compare each output handshake in order; check hold while stalled.
    logic        stall_prev = 1'b0;
    logic [11:0] held       = '0;
    always @(negedge clock) begin
        logic [11:0] w;
        if (!resetn) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) check("hold_stable", 32'(out_word()), 32'(held));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("out_unexpected", 32'(exp_q.size()), 32'd1);
                end else begin
                    w = exp_q.pop_front();
                    check("out_data", 32'(out_word()), 32'(w));
                    if (w[10]) exp_zero_hs++;
                    if (w[9])  exp_inf_hs++;
                end
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            held       = out_word();
        end
    end

    // ---------------- driver tasks ----------------
    // Called at #1 after a rising edge; returns at #1 after the accepting edge.
    task automatic send(input logic [7:0] v, input logic [11:0] e);
        bit acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_bits  = v;
        for (int c = 0; c < 100 && !acc; c++) begin
            @(negedge clock);
            acc = bus.in_ready;
            @(posedge clock);
            #1;
        end
        bus.in_valid = 1'b0;
        check("send_accept", {31'b0, acc}, 32'd1);
        if (acc) exp_q.push_back(e);
    endtask

    task automatic drain();
        for (int c = 0; c < 50 && exp_q.size() != 0; c++) begin
            @(posedge clock);
            #1;
        end
        @(posedge clock);
        #1;
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // One word into an empty pipe: visible after the second edge, not the first.
    task automatic latency_probe(input logic [7:0] v, input logic [11:0] e, input string tag);
        send(v, e);
        @(negedge clock);
        check({tag, "_early"}, {31'b0, bus.out_valid}, 32'd0);
        @(negedge clock);
        check({tag, "_ontime"}, {31'b0, bus.out_valid}, 32'd1);
        @(posedge clock);
        #1;
    endtask

    // ---------------- directed vectors ----------------
    logic [7:0]  vin  [12] = '{8'h56, 8'h0D, 8'h7F, 8'h81, 8'h00, 8'h80,
                               8'h40, 8'hC0, 8'h3F, 8'h5A, 8'h70, 8'h6C};
    logic [11:0] vexp [12] = '{12'h0D6, 12'h074, 12'h180, 12'h800, 12'h400, 12'h200,
                               12'h0C0, 12'h8C0, 12'h0BF, 12'h0DA, 12'h100, 12'h0F8};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_bits   = '0;
        bus.out_ready = 1'b1;

        // Reset state
        #12;
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_in_ready",  {31'b0, bus.in_ready},  32'd1);
        check("rst_out_word",  32'(out_word()),         32'd0);
`ifdef POSIT_DECODE_STATS_EN
        check("rst_stat_zero", stat_zero_count, 32'd0);
        check("rst_stat_inf",  stat_inf_count,  32'd0);
`endif
        @(posedge clock);
        #1;
        resetn = 1'b1;
        @(posedge clock);
        #1;

        // Latency on an empty pipe
        latency_probe(8'h56, 12'h0D6, "lat");

        // Back-to-back stream with out_ready held high
        for (int i = 0; i < 12; i++) send(vin[i], vexp[i]);
        drain();
`ifdef POSIT_DECODE_STATS_EN
        check("stat_zero", stat_zero_count, 32'(exp_zero_hs));
        check("stat_inf",  stat_inf_count,  32'(exp_inf_hs));
        check("stat_zero_one", stat_zero_count, 32'd1);
        check("stat_inf_one",  stat_inf_count,  32'd1);
`endif

        // Back-pressure: out_ready low from cycle 2 to 6 of a 5-word stream
        fork
            begin
                send(8'h3F, 12'h0BF);
                send(8'h0D, 12'h074);
                send(8'h6C, 12'h0F8);
                send(8'h81, 12'h800);
                send(8'h70, 12'h100);
            end
            begin
                repeat (2) @(posedge clock);
                #1;
                bus.out_ready = 1'b0;
                @(negedge clock);
                check("bp_in_ready_low", {31'b0, bus.in_ready},  32'd0);
                check("bp_out_valid",    {31'b0, bus.out_valid}, 32'd1);
                repeat (4) @(posedge clock);
                #1;
                check("bp_still_full", {31'b0, bus.in_ready}, 32'd0);
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Reset pulse with both stages full
        bus.out_ready = 1'b0;
        send(8'h5A, 12'h0DA);
        send(8'h7F, 12'h180);
        check("full_before_reset", {31'b0, bus.in_ready}, 32'd0);
        #2;
        resetn = 1'b0;
        #1;
        check("reset_async_valid", {31'b0, bus.out_valid}, 32'd0);
        check("reset_async_word",  32'(out_word()),         32'd0);
        exp_q.delete();
        exp_zero_hs   = 0;
        exp_inf_hs    = 0;
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1;
        resetn = 1'b1;
`ifdef POSIT_DECODE_STATS_EN
        check("reset_stat_zero", stat_zero_count, 32'd0);
`endif
        check("post_reset_ready", {31'b0, bus.in_ready}, 32'd1);
        latency_probe(8'h0D, 12'h074, "lat_after_reset");
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
